// File: rtl/voting_pkg.sv
// Shared definitions for the vote tally block: FSM state codes, winner codes,
// default passcode, count type, press-event struct and the winner rule.
// Latency: n/a (declarations only). Backpressure: n/a.
package voting_pkg;

  localparam int CNT_W = 7;
  typedef logic [CNT_W-1:0] cnt_t;

  // FSM state encodings, also driven straight out on the_state.
  localparam logic [1:0] ST_CLOSED = 2'd0;
  localparam logic [1:0] ST_OPEN   = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  // Winner codes; WIN_NONE also covers ties for first place and all-zero.
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_C1   = 2'd1;
  localparam logic [1:0] WIN_C2   = 2'd2;
  localparam logic [1:0] WIN_C3   = 2'd3;

  localparam logic [15:0] DEFAULT_PASSCODE = 16'hA5C3;

  // One cycle's worth of detected button rises.
  typedef struct packed {
    logic       ov;    // open/close button
    logic [2:0] cand;  // candidate buttons, bit 0 = btn1
  } btn_evt_t;

  // Strict maximum; any tie at the top (including all zero) gives WIN_NONE.
  function automatic logic [1:0] winner_of(input cnt_t c1, input cnt_t c2, input cnt_t c3);
    logic [1:0] w;
    w = WIN_NONE;
    if (c1 > c2 && c1 > c3)      w = WIN_C1;
    else if (c2 > c1 && c2 > c3) w = WIN_C2;
    else if (c3 > c1 && c3 > c2) w = WIN_C3;
    return w;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one debounced button level.
// Latency: rise pulses for one cycle, registered, one clock after level is first sampled high.
// Backpressure: none; a held level yields exactly one pulse.
// Ports: clk, rst_n (async active-low), level (button in), rise (one-cycle pulse out).
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// Three-candidate vote counter with passcode-guarded CLOSED->OPEN->RESULT FSM.
// Latency: count/total/vote_ack/vote_nak update one cycle after a button rise is detected;
//          the_winner follows one cycle after the counts.
// Backpressure: none; rejected presses (bad code, multi-press, saturation, not OPEN) pulse vote_nak.
// Ports: clk_100MHz, reset (async active-low), btn1..3, btn_ov_cv, sw[15:0] in;
//        count1..3[6:0], total[8:0], the_state[1:0], the_winner[1:0], vote_ack, vote_nak out;
//        nak_count[7:0] out only when TALLY_AUDIT_EN is defined.
module vote_tally
  import voting_pkg::*;
#(
  parameter int          MAX_COUNT = 99,
  parameter logic [15:0] PASSCODE  = DEFAULT_PASSCODE
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        btn1,
  input  logic        btn2,
  input  logic        btn3,
  input  logic        btn_ov_cv,
  input  logic [15:0] sw,
  output logic [6:0]  count1,
  output logic [6:0]  count2,
  output logic [6:0]  count3,
  output logic [8:0]  total,
  output logic [1:0]  the_state,
  output logic [1:0]  the_winner,
  output logic        vote_ack,
  output logic        vote_nak
`ifdef TALLY_AUDIT_EN
  ,
  output logic [7:0]  nak_count
`endif
);

  localparam cnt_t MAX_C = cnt_t'(MAX_COUNT);

  logic       rise1, rise2, rise3, rise_ov;
  btn_evt_t   evt;
  logic [1:0] n_cand;

  logic [1:0]       state, state_d;
  cnt_t [2:0]       cnt, cnt_d;
  logic             ack_d, nak_d;
  logic             enter_open;

  edge_detect u_ed_btn1 (.clk(clk_100MHz), .rst_n(reset), .level(btn1),      .rise(rise1));
  edge_detect u_ed_btn2 (.clk(clk_100MHz), .rst_n(reset), .level(btn2),      .rise(rise2));
  edge_detect u_ed_btn3 (.clk(clk_100MHz), .rst_n(reset), .level(btn3),      .rise(rise3));
  edge_detect u_ed_ov   (.clk(clk_100MHz), .rst_n(reset), .level(btn_ov_cv), .rise(rise_ov));

  assign evt    = '{ov: rise_ov, cand: {rise3, rise2, rise1}};
  assign n_cand = {1'b0, rise1} + {1'b0, rise2} + {1'b0, rise3};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ack_d   = 1'b0;
    nak_d   = 1'b0;

    if (evt.ov) begin
      // Open/close wins; any candidate rise in the same cycle is dropped without a nak.
      if (sw == PASSCODE) begin
        case (state)
          ST_CLOSED: state_d = ST_OPEN;
          ST_OPEN:   state_d = ST_RESULT;
          default:   state_d = ST_CLOSED;
        endcase
      end else begin
        nak_d = 1'b1;
      end
    end else if (n_cand > 2'd1) begin
      nak_d = 1'b1;
    end else if (n_cand == 2'd1) begin
      if (state != ST_OPEN) begin
        nak_d = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (evt.cand[i]) begin
            if (cnt[i] == MAX_C) begin
              nak_d = 1'b1;
            end else begin
              cnt_d[i] = cnt[i] + cnt_t'(1);
              ack_d    = 1'b1;
            end
          end
        end
      end
    end

    enter_open = (state_d == ST_OPEN) && (state != ST_OPEN);
    if (enter_open) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLOSED;
      cnt        <= '0;
      vote_ack   <= 1'b0;
      vote_nak   <= 1'b0;
      the_winner <= WIN_NONE;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      vote_ack <= ack_d;
      vote_nak <= nak_d;
      // Re-evaluated every cycle from the registered counts, so it trails any
      // count change by exactly one cycle; forced to none when a vote opens.
      if (enter_open) the_winner <= WIN_NONE;
      else            the_winner <= winner_of(cnt[0], cnt[1], cnt[2]);
    end
  end

`ifdef TALLY_AUDIT_EN
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      nak_count <= 8'd0;
    end else if (enter_open) begin
      nak_count <= 8'd0;
    end else if (vote_nak && nak_count != 8'hFF) begin
      nak_count <= nak_count + 8'd1;
    end
  end
`endif

  assign count1    = cnt[0];
  assign count2    = cnt[1];
  assign count3    = cnt[2];
  // Combinational sum keeps total consistent with the counts in every cycle.
  assign total     = {2'b00, cnt[0]} + {2'b00, cnt[1]} + {2'b00, cnt[2]};
  assign the_state = state;

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: two instances (default MAX_COUNT and MAX_COUNT=3) share
// stimulus; a press-level reference model predicts counts, state, winner and
// ack/nak totals after each completed press.
`timescale 1ns/1ps
module tb_vote_tally;

  localparam logic [15:0] PASS = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b1, b2, b3, bov;
  logic [15:0] sw;

  logic [6:0] cnt_o  [2][3];
  logic [8:0] total_o[2];
  logic [1:0] st_o   [2];
  logic [1:0] win_o  [2];
  logic       ack_o  [2];
  logic       nak_o  [2];
`ifdef TALLY_AUDIT_EN
  logic [7:0] nakc_o [2];
`endif

  always #5 clk = ~clk;

  vote_tally dut (
    .clk_100MHz(clk), .reset(rst_n),
    .btn1(b1), .btn2(b2), .btn3(b3), .btn_ov_cv(bov), .sw(sw),
    .count1(cnt_o[0][0]), .count2(cnt_o[0][1]), .count3(cnt_o[0][2]),
    .total(total_o[0]), .the_state(st_o[0]), .the_winner(win_o[0]),
    .vote_ack(ack_o[0]), .vote_nak(nak_o[0])
`ifdef TALLY_AUDIT_EN
    , .nak_count(nakc_o[0])
`endif
  );

  vote_tally #(.MAX_COUNT(3)) dut_sat (
    .clk_100MHz(clk), .reset(rst_n),
    .btn1(b1), .btn2(b2), .btn3(b3), .btn_ov_cv(bov), .sw(sw),
    .count1(cnt_o[1][0]), .count2(cnt_o[1][1]), .count3(cnt_o[1][2]),
    .total(total_o[1]), .the_state(st_o[1]), .the_winner(win_o[1]),
    .vote_ack(ack_o[1]), .vote_nak(nak_o[1])
`ifdef TALLY_AUDIT_EN
    , .nak_count(nakc_o[1])
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Pulse monitor: counts every cycle each instance asserts ack / nak.
  int ack_seen[2];
  int nak_seen[2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack_o[i] === 1'b1) ack_seen[i]++;
      if (nak_o[i] === 1'b1) nak_seen[i]++;
    end
  end

  // Reference model, one update per completed press.
  int m_cnt[2][3];
  int m_state[2];
  int m_ack[2];
  int m_nak[2];
  int m_nakc[2];
  int m_max[2] = '{99, 3};

  function automatic int m_winner(input int i);
    int best, nbest, w;
    best = 0; nbest = 0; w = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_cnt[i][k] > best) begin
        best = m_cnt[i][k]; nbest = 1; w = k + 1;
      end else if (m_cnt[i][k] == best && best > 0) begin
        nbest++;
      end
    end
    return (best == 0 || nbest != 1) ? 0 : w;
  endfunction

  task automatic m_nak_evt(input int i);
    m_nak[i]++;
    if (m_nakc[i] < 255) m_nakc[i]++;
  endtask

  task automatic model_apply(input logic [2:0] cand, input logic ov, input logic [15:0] s);
    int k;
    for (int i = 0; i < 2; i++) begin
      if (ov) begin
        if (s == PASS) begin
          m_state[i] = (m_state[i] + 1) % 3;
          if (m_state[i] == 1) begin
            for (int j = 0; j < 3; j++) m_cnt[i][j] = 0;
            m_nakc[i] = 0;
          end
        end else begin
          m_nak_evt(i);
        end
      end else if ($countones(cand) >= 2) begin
        m_nak_evt(i);
      end else if (cand != 3'b000) begin
        k = cand[0] ? 0 : (cand[1] ? 1 : 2);
        if (m_state[i] != 1 || m_cnt[i][k] >= m_max[i]) m_nak_evt(i);
        else begin
          m_cnt[i][k]++;
          m_ack[i]++;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_nakc[i]  = 0;
      for (int j = 0; j < 3; j++) m_cnt[i][j] = 0;
    end
  endtask

  task automatic check_all(input string where);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s c1[%0d]", where, i), int'(cnt_o[i][0]), m_cnt[i][0]);
      chk($sformatf("%s c2[%0d]", where, i), int'(cnt_o[i][1]), m_cnt[i][1]);
      chk($sformatf("%s c3[%0d]", where, i), int'(cnt_o[i][2]), m_cnt[i][2]);
      chk($sformatf("%s total[%0d]", where, i), int'(total_o[i]),
          m_cnt[i][0] + m_cnt[i][1] + m_cnt[i][2]);
      chk($sformatf("%s state[%0d]", where, i), int'(st_o[i]), m_state[i]);
      chk($sformatf("%s winner[%0d]", where, i), int'(win_o[i]), m_winner(i));
      chk($sformatf("%s acks[%0d]", where, i), ack_seen[i], m_ack[i]);
      chk($sformatf("%s naks[%0d]", where, i), nak_seen[i], m_nak[i]);
`ifdef TALLY_AUDIT_EN
      chk($sformatf("%s nak_count[%0d]", where, i), int'(nakc_o[i]), m_nakc[i]);
`endif
    end
  endtask

  // Raise the given buttons together, hold 1..4 cycles, release, let results settle.
  task automatic press(input logic [2:0] cand, input logic ov, input logic [15:0] s);
    int h;
    h = $urandom_range(1, 4);
    @(negedge clk);
    sw = s;
    {b3, b2, b1} = cand;
    bov = ov;
    repeat (h) @(negedge clk);
    {b3, b2, b1} = 3'b000;
    bov = 1'b0;
    repeat (3) @(negedge clk);
    model_apply(cand, ov, s);
  endtask

  task automatic open_fresh();
    for (int n = 0; n < 3 && m_state[0] != 1; n++) press(3'b000, 1'b1, PASS);
    chk("open_fresh state", int'(st_o[0]), 1);
  endtask

  task automatic reset_check_now(input string where);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s state[%0d]", where, i), int'(st_o[i]), 0);
      chk($sformatf("%s c1[%0d]", where, i), int'(cnt_o[i][0]), 0);
      chk($sformatf("%s c2[%0d]", where, i), int'(cnt_o[i][1]), 0);
      chk($sformatf("%s c3[%0d]", where, i), int'(cnt_o[i][2]), 0);
      chk($sformatf("%s total[%0d]", where, i), int'(total_o[i]), 0);
      chk($sformatf("%s winner[%0d]", where, i), int'(win_o[i]), 0);
      chk($sformatf("%s ack[%0d]", where, i), int'(ack_o[i]), 0);
      chk($sformatf("%s nak[%0d]", where, i), int'(nak_o[i]), 0);
    end
  endtask

  initial begin
    int a0, n0, a1, n1;
    logic [2:0]  cm;
    logic [15:0] sv;
    int r;

    rst_n = 1'b1;
    {b3, b2, b1} = 3'b000;
    bov = 1'b0;
    sw = 16'h0000;
    model_reset();
    #1 rst_n = 1'b0;
    #1 reset_check_now("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("after_reset");

    // Wrong code in CLOSED, then a candidate press while CLOSED.
    n0 = nak_seen[0];
    press(3'b000, 1'b1, 16'h0000);
    chk("badcode state", int'(st_o[0]), 0);
    chk("badcode nak", nak_seen[0] - n0, 1);
    press(3'b001, 1'b0, 16'h0000);
    chk("closed btn1 c1", int'(cnt_o[0][0]), 0);
    check_all("closed");

    // Open, 3x btn1 and 1x btn2.
    open_fresh();
    a0 = ack_seen[0];
    repeat (3) press(3'b001, 1'b0, PASS);
    press(3'b010, 1'b0, PASS);
    chk("s1 c1", int'(cnt_o[0][0]), 3);
    chk("s1 c2", int'(cnt_o[0][1]), 1);
    chk("s1 total", int'(total_o[0]), 4);
    chk("s1 winner", int'(win_o[0]), 1);
    chk("s1 acks", ack_seen[0] - a0, 4);
    check_all("s1");

    // btn1 and btn3 together: one rejected press.
    n0 = nak_seen[0];
    press(3'b101, 1'b0, PASS);
    chk("dual c1", int'(cnt_o[0][0]), 3);
    chk("dual c3", int'(cnt_o[0][2]), 0);
    chk("dual nak", nak_seen[0] - n0, 1);
    check_all("dual");

    // Saturation on the MAX_COUNT=3 instance.
    press(3'b000, 1'b1, PASS);
    press(3'b000, 1'b1, PASS);
    open_fresh();
    a1 = ack_seen[1]; n1 = nak_seen[1];
    repeat (5) press(3'b010, 1'b0, PASS);
    chk("sat c2", int'(cnt_o[1][1]), 3);
    chk("sat acks", ack_seen[1] - a1, 3);
    chk("sat naks", nak_seen[1] - n1, 2);
    chk("nosat c2", int'(cnt_o[0][1]), 5);
    check_all("sat");

    // Tie, then a tie-break with cycle-exact latency checks.
    press(3'b000, 1'b1, PASS);
    press(3'b000, 1'b1, PASS);
    open_fresh();
    repeat (2) press(3'b001, 1'b0, PASS);
    repeat (2) press(3'b100, 1'b0, PASS);
    chk("tie winner", int'(win_o[0]), 0);
    @(negedge clk);
    b3 = 1'b1;
    @(negedge clk);
    chk("lat c3 before", int'(cnt_o[0][2]), 2);
    chk("lat ack before", int'(ack_o[0]), 0);
    @(negedge clk);
    chk("lat c3 after", int'(cnt_o[0][2]), 3);
    chk("lat total after", int'(total_o[0]), 5);
    chk("lat ack pulse", int'(ack_o[0]), 1);
    chk("lat winner lag", int'(win_o[0]), 0);
    b3 = 1'b0;
    @(negedge clk);
    chk("lat ack end", int'(ack_o[0]), 0);
    chk("lat winner", int'(win_o[0]), 3);
    repeat (2) @(negedge clk);
    model_apply(3'b100, 1'b0, PASS);
    check_all("tiebreak");

    // Close with a simultaneous candidate press (dropped silently), then to CLOSED.
    n0 = nak_seen[0];
    press(3'b001, 1'b1, PASS);
    chk("prio state", int'(st_o[0]), 2);
    chk("prio c1", int'(cnt_o[0][0]), 2);
    chk("prio nak", nak_seen[0] - n0, 0);
    press(3'b000, 1'b1, PASS);
    chk("closed keep winner", int'(win_o[0]), 3);
    check_all("result_closed");

    // Randomised presses.
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 99);
      sv = 16'($urandom);
      if (sv == PASS) sv = 16'h0000;
      cm = 3'b000;
      if (r < 10) begin
        if ($urandom_range(0, 1) == 1) cm = 3'($urandom);
        press(cm, 1'b1, PASS);
      end else if (r < 15) begin
        press(3'b000, 1'b1, sv);
      end else begin
        if (r < 80) cm = 3'b001 << $urandom_range(0, 2);
        else        cm = 3'($urandom_range(1, 7));
        press(cm, 1'b0, sv);
      end
      check_all($sformatf("rnd%0d", t));
    end

    // Asynchronous reset while OPEN with count1 = 5.
    open_fresh();
    repeat (5) press(3'b001, 1'b0, PASS);
    chk("pre_reset c1", int'(cnt_o[0][0]), 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_check_now("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("after_async_reset");

    // Reset while a vote is in flight leaves nothing behind.
    open_fresh();
    @(negedge clk);
    b1 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    b1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all("midvote_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
